uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (5..8).
REQ-002 Parameter OVERSAMPLE, default 16, rx_tick pulses per bit period (power of two, 8 or 16).
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 rx_tick  input  1  single-cycle oversample strobe from the baud-rate generator's rx_tick output.
REQ-006 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-007 rx_data  output  DATA_BITS  last correctly framed byte, LSB = first data bit received.
REQ-008 rx_valid  output  1  single-cycle pulse, rx_data updated this cycle.
REQ-009 frame_err  output  1  single-cycle pulse, stop bit sampled low.
REQ-010 busy  output  1  high whenever FSM not in IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (reset value 1); all FSM decisions use the synchronized value rx_s.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP; tick counter tcnt is log2(OVERSAMPLE) bits; bit counter bcnt is 0..DATA_BITS-1.
REQ-013 IDLE: rx_s==0 on any clk edge -> START, tcnt=0; rx_tick is not required for this transition.
REQ-014 START: on each rx_tick tcnt increments; on the rx_tick where tcnt==OVERSAMPLE/2-1: rx_s==0 -> DATA with tcnt=0, bcnt=0; rx_s==1 -> IDLE (glitch rejected, no output pulse).
REQ-015 DATA: on each rx_tick tcnt increments, wrapping; on the rx_tick where tcnt==OVERSAMPLE-1, rx_s SHALL be shifted into the MSB of the shift register (right shift), then bcnt increments; after the DATA_BITS-th sample -> STOP with tcnt=0.
REQ-016 STOP: on the rx_tick where tcnt==OVERSAMPLE-1: rx_s==1 -> rx_data<=shift register, rx_valid=1; rx_s==0 -> frame_err=1, rx_data unchanged; both cases -> IDLE.
REQ-017 rx_valid and frame_err SHALL be registered, high exactly one clk cycle, asserted the cycle after the sampling rx_tick edge, and never high together.
REQ-018 Clock cycles without rx_tick SHALL leave tcnt, bcnt and state unchanged (except IDLE->START per REQ-013).
REQ-019 After frame_err, IDLE SHALL re-enter START only on rx_s low; a line held low (break) produces one frame_err per 1+DATA_BITS+1 bit periods.
REQ-020 Back-to-back frames: a start edge arriving in the cycle after STOP exits SHALL be accepted with no lost bits.
REQ-021 rx_data SHALL hold its value until the next rx_valid; no overrun detection is provided.

Reset
REQ-022 rst_n low SHALL immediately force: state IDLE, tcnt=0, bcnt=0, shift register 0, rx_data 0, rx_valid 0, frame_err 0, busy 0, synchronizer flops 1.
REQ-023 Reset asserted mid-frame SHALL discard the partial frame with no output pulse; after release the block waits for a fresh start edge.
REQ-024 Deassertion is synchronous to clk by the system; the first edge after release may begin reception.

Verification
REQ-025 Frame 0xA5 (8N1, 16 ticks/bit) -> one rx_valid pulse, rx_data=0xA5, frame_err never high, busy low after pulse.
REQ-026 Frames 0x00 then 0xFF back-to-back with zero idle bits -> two rx_valid pulses, rx_data 0x00 then 0xFF.
REQ-027 Frame 0x3C with stop bit driven low -> one frame_err pulse, no rx_valid, rx_data keeps prior value.
REQ-028 rx low for 4 rx_ticks then high -> busy rises then falls at 8th tick, no rx_valid, no frame_err.
REQ-029 rst_n pulsed low during data bit 4 of 0x5A, then valid frame 0xC3 -> only rx_valid with rx_data=0xC3.
REQ-030 rx_tick gapped irregularly (1-7 idle cycles between ticks), frame 0x81 -> rx_valid with rx_data=0x81.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: oversampled start-bit qualification, mid-bit data sampling,
// stop-bit check with single-cycle rx_valid / frame_err pulses.
module uart_rx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    // DATA_BITS is at least 5, so BW is never narrower than 3 bits
    localparam int unsigned BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] TcntHalf = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TcntLast = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BcntLast = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e                 state_q, state_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic [BW-1:0]          bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   rx_meta_q, rx_s_q;

    // Two-flop synchronizer; resets to the idle line level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Start edge is taken on any clock, independent of rx_tick
                if (!rx_s_q) begin
                    state_d = StStart;
                    tcnt_d  = '0;
                end
            end

            StStart: begin
                if (rx_tick) begin
                    if (tcnt_q == TcntHalf) begin
                        tcnt_d = '0;
                        if (!rx_s_q) begin
                            state_d = StData;
                            bcnt_d  = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end

            StData: begin
                if (rx_tick) begin
                    tcnt_d = tcnt_q + 1'b1;
                    if (tcnt_q == TcntLast) begin
                        shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        if (bcnt_q == BcntLast) begin
                            state_d = StStop;
                            bcnt_d  = '0;
                            tcnt_d  = '0;
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end
                end
            end

            StStop: begin
                if (rx_tick) begin
                    if (tcnt_q == TcntLast) begin
                        tcnt_d  = '0;
                        state_d = StIdle;
                        if (rx_s_q) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = StIdle;
                tcnt_d  = '0;
                bcnt_d  = '0;
            end
        endcase
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus a randomized frame stream
// checked against a byte/stop-bit level model.
`timescale 1ns / 1ps
module tb_uart_rx;

    localparam int DB = 8;
    localparam int OS = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          rx_tick = 1'b0;
    logic          rx = 1'b1;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          busy;

    uart_rx #(
        .DATA_BITS (DB),
        .OVERSAMPLE(OS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_tick  (rx_tick),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observed output events
    logic [DB-1:0] valid_q[$];
    int            fe_cnt = 0;
    int            both_cnt = 0;

    int max_gap = 2;
    int fixed_gap = -1;

    always @(negedge clk) begin
        if (rx_valid) valid_q.push_back(rx_data);
        if (frame_err) fe_cnt++;
        if (rx_valid && frame_err) both_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_events();
        valid_q.delete();
        fe_cnt   = 0;
        both_cnt = 0;
    endtask

    // One rx_tick pulse, preceded by 0..max_gap extra idle cycles
    task automatic tick();
        int g;
        g = (fixed_gap >= 0) ? fixed_gap : int'($urandom_range(max_gap, 0));
        repeat (g) @(negedge clk);
        rx_tick = 1'b1;
        @(negedge clk);
        rx_tick = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic bit_ticks(input logic v, input int n);
        rx = v;
        repeat (n) tick();
    endtask

    task automatic idle_bits(input int n);
        bit_ticks(1'b1, n * OS);
    endtask

    // A bad stop bit is low for 3/4 of the bit, so the receiver's rearm after the
    // error sees the line high again before its start-bit check
    task automatic send_frame(input logic [DB-1:0] d, input logic stop_ok);
        bit_ticks(1'b0, OS);
        for (int i = 0; i < DB; i++) bit_ticks(d[i], OS);
        if (stop_ok) begin
            bit_ticks(1'b1, OS);
        end else begin
            bit_ticks(1'b0, OS - OS / 4);
            bit_ticks(1'b1, OS / 4);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (rx_data !== '0) begin errors++; $display("FAIL reset_rx_data got %0h exp 0", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %0b exp 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %0b exp 0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %0b exp 0", busy); end
    endtask

    task automatic test_basic();
        logic [DB-1:0] got;
        clear_events();
        send_frame(8'hA5, 1'b1);
        idle_bits(1);
        got = (valid_q.size() > 0) ? valid_q[0] : 'x;
        checks++; if (valid_q.size() != 1) begin errors++; $display("FAIL basic_count got %0d exp 1", valid_q.size()); end
        checks++; if (got !== 8'hA5) begin errors++; $display("FAIL basic_data got %0h exp a5", got); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL basic_rx_data got %0h exp a5", rx_data); end
        checks++; if (fe_cnt != 0) begin errors++; $display("FAIL basic_ferr got %0d exp 0", fe_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %0b exp 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [DB-1:0] g0, g1;
        clear_events();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle_bits(1);
        g0 = (valid_q.size() > 0) ? valid_q[0] : 'x;
        g1 = (valid_q.size() > 1) ? valid_q[1] : 'x;
        checks++; if (valid_q.size() != 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", valid_q.size()); end
        checks++; if (g0 !== 8'h00) begin errors++; $display("FAIL b2b_first got %0h exp 00", g0); end
        checks++; if (g1 !== 8'hFF) begin errors++; $display("FAIL b2b_second got %0h exp ff", g1); end
        checks++; if (fe_cnt != 0) begin errors++; $display("FAIL b2b_ferr got %0d exp 0", fe_cnt); end
    endtask

    task automatic test_frame_err(input logic [DB-1:0] prior);
        clear_events();
        send_frame(8'h3C, 1'b0);
        idle_bits(1);
        checks++; if (fe_cnt != 1) begin errors++; $display("FAIL ferr_count got %0d exp 1", fe_cnt); end
        checks++; if (valid_q.size() != 0) begin errors++; $display("FAIL ferr_valid got %0d exp 0", valid_q.size()); end
        checks++; if (rx_data !== prior) begin errors++; $display("FAIL ferr_hold got %0h exp %0h", rx_data, prior); end
        checks++; if (both_cnt != 0) begin errors++; $display("FAIL ferr_both got %0d exp 0", both_cnt); end
    endtask

    // Wide tick spacing so the very first tick after the falling edge is counted
    task automatic test_glitch();
        clear_events();
        fixed_gap = 4;
        rx = 1'b0;
        repeat (4) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise got %0b exp 1", busy); end
        rx = 1'b1;
        repeat (3) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_tick7 got %0b exp 1", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_tick8 got %0b exp 0", busy); end
        fixed_gap = -1;
        idle_bits(1);
        checks++; if (valid_q.size() != 0) begin errors++; $display("FAIL glitch_valid got %0d exp 0", valid_q.size()); end
        checks++; if (fe_cnt != 0) begin errors++; $display("FAIL glitch_ferr got %0d exp 0", fe_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [DB-1:0] d;
        logic [DB-1:0] got;
        d = 8'h5A;
        clear_events();
        bit_ticks(1'b0, OS);
        for (int i = 0; i < 4; i++) bit_ticks(d[i], OS);
        bit_ticks(d[4], OS / 2);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b exp 0", busy); end
        checks++; if (rx_data !== '0) begin errors++; $display("FAIL rstmid_rx_data got %0h exp 0", rx_data); end
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_bits(1);
        send_frame(8'hC3, 1'b1);
        idle_bits(1);
        got = (valid_q.size() > 0) ? valid_q[0] : 'x;
        checks++; if (valid_q.size() != 1) begin errors++; $display("FAIL rstmid_count got %0d exp 1", valid_q.size()); end
        checks++; if (got !== 8'hC3) begin errors++; $display("FAIL rstmid_data got %0h exp c3", got); end
        checks++; if (fe_cnt != 0) begin errors++; $display("FAIL rstmid_ferr got %0d exp 0", fe_cnt); end
    endtask

    task automatic test_gapped();
        logic [DB-1:0] got;
        clear_events();
        max_gap = 6;
        send_frame(8'h81, 1'b1);
        idle_bits(1);
        max_gap = 2;
        got = (valid_q.size() > 0) ? valid_q[0] : 'x;
        checks++; if (valid_q.size() != 1) begin errors++; $display("FAIL gapped_count got %0d exp 1", valid_q.size()); end
        checks++; if (got !== 8'h81) begin errors++; $display("FAIL gapped_data got %0h exp 81", got); end
    endtask

    // Held-low line: frame errors repeat roughly once per start+data+stop period
    task automatic test_break();
        int t, t1, t2;
        clear_events();
        t = 0;
        t1 = -1;
        t2 = -1;
        rx = 1'b0;
        for (int k = 0; k < 3 * (DB + 2) * OS; k++) begin
            tick();
            t++;
            if (fe_cnt >= 1 && t1 < 0) t1 = t;
            if (fe_cnt >= 2) begin
                t2 = t;
                break;
            end
        end
        rx = 1'b1;
        checks++; if (t2 < 0) begin errors++; $display("FAIL break_timeout got %0d errors exp 2", fe_cnt); end
        checks++;
        if (t2 >= 0 && ((t2 - t1) < (DB + 1) * OS || (t2 - t1) > (DB + 2) * OS)) begin
            errors++;
            $display("FAIL break_period got %0d ticks exp %0d..%0d", t2 - t1, (DB + 1) * OS, (DB + 2) * OS);
        end
        idle_bits(2);
        checks++; if (fe_cnt != 2) begin errors++; $display("FAIL break_ferr got %0d exp 2", fe_cnt); end
        checks++; if (valid_q.size() != 0) begin errors++; $display("FAIL break_valid got %0d exp 0", valid_q.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_busy got %0b exp 0", busy); end
    endtask

    task automatic test_random(input int n, input logic [DB-1:0] prior);
        logic [DB-1:0] exp_q[$];
        logic [DB-1:0] last_good;
        logic [DB-1:0] d, got;
        logic          ok;
        int            exp_fe;
        clear_events();
        exp_fe    = 0;
        last_good = prior;
        max_gap   = 3;
        for (int i = 0; i < n; i++) begin
            d  = DB'($urandom);
            ok = ($urandom_range(3, 0) != 0);
            send_frame(d, ok);
            if (ok) begin
                exp_q.push_back(d);
                last_good = d;
                idle_bits(int'($urandom_range(1, 0)));
            end else begin
                exp_fe++;
                idle_bits(1 + int'($urandom_range(1, 0)));
                checks++;
                if (rx_data !== last_good) begin
                    errors++;
                    $display("FAIL rand_hold[%0d] got %0h exp %0h", i, rx_data, last_good);
                end
            end
        end
        max_gap = 2;
        checks++; if (valid_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d exp %0d", valid_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < valid_q.size()) ? valid_q[i] : 'x;
            checks++;
            if (got !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_data[%0d] got %0h exp %0h", i, got, exp_q[i]);
            end
        end
        checks++; if (fe_cnt != exp_fe) begin errors++; $display("FAIL rand_ferr got %0d exp %0d", fe_cnt, exp_fe); end
        checks++; if (both_cnt != 0) begin errors++; $display("FAIL rand_both got %0d exp 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_frame_err(8'hFF);
        test_glitch();
        test_reset_mid();
        test_gapped();
        test_break();
        test_random(24, 8'h81);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
